// File: rtl/hs_tx_pkg.sv
// Shared types and constants for the handshake fork transmitter.
package hs_tx_pkg;

    localparam int HS_TX_WIDTH = 5;
    localparam int HS_TX_NOUT  = 3;
    localparam int HS_TX_DEPTH = 2;

    typedef logic [HS_TX_WIDTH-1:0] hs_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SEND  = 2'd1,
        PART  = 2'd2
    } hs_tx_state_e;

    function automatic logic [3:0] hs_tx_popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/handshake_fork_tx_if.sv
// Handshake bundle for the fork transmitter: one upstream channel, N_OUT downstream channels.
interface handshake_fork_tx_if
    import hs_tx_pkg::*;
#(
    parameter int WIDTH = HS_TX_WIDTH,
    parameter int N_OUT = HS_TX_NOUT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] out_ready;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       stall_cnt;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, stall_cnt
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, stall_cnt
    );

endinterface

// File: rtl/hs_tx_fifo.sv
// Small power-of-two FIFO holding payload beats; pointers wrap naturally at DEPTH.
module hs_tx_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_nxt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign count_nxt_o = count_d;

endmodule

// File: rtl/handshake_fork_tx.sv
// Eager fork transmitter: buffers upstream beats and broadcasts each head to N_OUT channels.
// Optional embedded SVA enabled by defining HS_FORK_TX_ASSERT_EN.
//
//  state | meaning
//  EMPTY | no beat buffered
//  SEND  | head presented, no channel has taken it yet
//  PART  | head taken by some but not all channels
module handshake_fork_tx
    import hs_tx_pkg::*;
#(
    parameter int WIDTH = HS_TX_WIDTH,
    parameter int N_OUT = HS_TX_NOUT,
    parameter int DEPTH = HS_TX_DEPTH
) (
    input logic                CLK,
    input logic                ASYNCRESETN,
    handshake_fork_tx_if.master bus
);

    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [WIDTH-1:0]       head_data;
    logic [$clog2(DEPTH):0] count_nxt;
    logic                   rdy_en_q;
    logic                   in_ready;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       fire;
    logic [N_OUT-1:0]       stalled;
    logic [N_OUT-1:0]       done_q;
    logic [N_OUT-1:0]       done_d;
    logic [7:0]             stall_q;
    logic [7:0]             stall_d;
    logic [8:0]             stall_sum;
    hs_tx_state_e           state_q;
    hs_tx_state_e           state_d;

    hs_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .push_i      (push),
        .wdata_i     (bus.in_data),
        .pop_i       (pop),
        .rdata_o     (head_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_nxt_o (count_nxt)
    );

    // Ready depends only on registered state; rdy_en_q holds it low until the first edge after reset.
    assign in_ready  = rdy_en_q & ~fifo_full;
    assign push      = bus.in_valid & in_ready;
    assign out_valid = fifo_empty ? '0 : ~done_q;
    assign fire      = out_valid & bus.out_ready;
    assign stalled   = out_valid & ~bus.out_ready;
    assign pop       = (state_q != EMPTY) && ((done_q | fire) == '1);
    assign done_d    = pop ? '0 : (done_q | fire);

    assign stall_sum = {1'b0, stall_q} + {5'b00000, hs_tx_popcount8(8'(stalled))};
    assign stall_d   = stall_sum[8] ? 8'hFF : stall_sum[7:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push) state_d = SEND;
            end
            SEND, PART: begin
                if (pop) begin
                    state_d = (count_nxt != '0) ? SEND : EMPTY;
                end else if (fire != '0) begin
                    state_d = PART;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q  <= EMPTY;
            done_q   <= '0;
            stall_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            stall_q  <= stall_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head_data;
    assign bus.stall_cnt = stall_q;

`ifdef HS_FORK_TX_ASSERT_EN
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_hold
        a_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            (out_valid[gi] && !bus.out_ready[gi]) |=> (out_valid[gi] && $stable(head_data)));
    end

    a_no_push_full: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        !(push && fifo_full));

    a_done_clears: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (&done_q) |=> !(&done_q));
`endif

endmodule

// File: tb/tb_handshake_fork_tx.sv
// Directed and random checks of the fork transmitter against hand-computed values and a reference queue.
module tb_handshake_fork_tx;
    import hs_tx_pkg::*;

    localparam int W = HS_TX_WIDTH;
    localparam int N = HS_TX_NOUT;

    logic CLK         = 1'b0;
    logic ASYNCRESETN = 1'b0;
    int   n_vec       = 0;
    int   n_err       = 0;

    handshake_fork_tx_if #(.WIDTH(W), .N_OUT(N)) bus ();

    handshake_fork_tx #(
        .WIDTH (W),
        .N_OUT (N),
        .DEPTH (HS_TX_DEPTH)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .bus         (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    hs_payload_t hist[$];
    int          recv [N];
    int          minr;
    int          occ;
    logic [N-1:0] exp_v;
    logic        exp_rdy;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = '0;

        // reset values while held low
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_stall", 32'(bus.stall_cnt), 32'h0);

        // single beat, all channels ready
        bus.in_valid  = 1'b1;
        bus.in_data   = 5'h0A;
        bus.out_ready = 3'b111;
        #11;
        ASYNCRESETN = 1'b1;
        tick();
        chk("t1_in_ready", 32'(bus.in_ready), 32'h1);
        chk("t1_no_bypass", 32'(bus.out_valid), 32'h0);
        tick();
        bus.in_valid = 1'b0;
        chk("t1_valid", 32'(bus.out_valid), 32'h7);
        chk("t1_data", 32'(bus.out_data), 32'h0A);
        tick();
        chk("t1_retired", 32'(bus.out_valid), 32'h0);
        chk("t1_ready_after", 32'(bus.in_ready), 32'h1);
        chk("t1_stall", 32'(bus.stall_cnt), 32'h0);

        // fill with nobody ready, stall counter saturates
        bus.out_ready = 3'b000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 5'h01;
        tick();
        chk("t2_ready1", 32'(bus.in_ready), 32'h1);
        chk("t2_valid", 32'(bus.out_valid), 32'h7);
        chk("t2_data1", 32'(bus.out_data), 32'h01);
        bus.in_data = 5'h02;
        tick();
        bus.in_data = 5'h03;
        chk("t2_full", 32'(bus.in_ready), 32'h0);
        chk("t2_stall3", 32'(bus.stall_cnt), 32'd3);
        tick(83);
        chk("t2_stall252", 32'(bus.stall_cnt), 32'd252);
        chk("t2_data_hold", 32'(bus.out_data), 32'h01);
        chk("t2_full_hold", 32'(bus.in_ready), 32'h0);
        tick();
        chk("t2_stall255", 32'(bus.stall_cnt), 32'd255);
        tick(2);
        chk("t2_stall_sat", 32'(bus.stall_cnt), 32'd255);
        bus.in_valid = 1'b0;

        // drain 01, 02
        bus.out_ready = 3'b111;
        tick();
        chk("t2_drain_data", 32'(bus.out_data), 32'h02);
        chk("t2_drain_valid", 32'(bus.out_valid), 32'h7);
        tick();
        chk("t2_drained", 32'(bus.out_valid), 32'h0);

        // staggered completion of head 11, with 12 queued behind
        bus.out_ready = 3'b000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 5'h11;
        tick();
        bus.in_data = 5'h12;
        tick();
        bus.in_valid = 1'b0;
        chk("t3_valid0", 32'(bus.out_valid), 32'h7);
        chk("t3_head", 32'(bus.out_data), 32'h11);
        bus.out_ready = 3'b001;
        tick();
        chk("t3_valid1", 32'(bus.out_valid), 32'h6);
        chk("t3_head_hold", 32'(bus.out_data), 32'h11);
        bus.out_ready = 3'b100;
        tick();
        chk("t3_valid2", 32'(bus.out_valid), 32'h2);
        bus.out_ready = 3'b010;
        tick();
        chk("t3_next_valid", 32'(bus.out_valid), 32'h7);
        chk("t3_next_data", 32'(bus.out_data), 32'h12);
        chk("t3_ready", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 3'b111;
        tick();
        chk("t3_empty", 32'(bus.out_valid), 32'h0);

        // full FIFO with retire in the same cycle: push blocked, then taken next cycle
        bus.out_ready = 3'b000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 5'h05;
        tick();
        bus.in_data = 5'h06;
        tick();
        bus.in_data   = 5'h07;
        bus.out_ready = 3'b111;
        #1;
        chk("t4_full_no_comb", 32'(bus.in_ready), 32'h0);
        chk("t4_head05", 32'(bus.out_data), 32'h05);
        tick();
        chk("t4_head06", 32'(bus.out_data), 32'h06);
        chk("t4_valid06", 32'(bus.out_valid), 32'h7);
        chk("t4_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        chk("t4_head07", 32'(bus.out_data), 32'h07);
        chk("t4_valid07", 32'(bus.out_valid), 32'h7);
        tick();
        chk("t4_empty", 32'(bus.out_valid), 32'h0);

        // reset mid-PART
        bus.out_ready = 3'b000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 5'h11;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 3'b001;
        tick();
        chk("t5_part", 32'(bus.out_valid), 32'h6);
        bus.out_ready = 3'b000;
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("t5_rst_ready", 32'(bus.in_ready), 32'h0);
        chk("t5_rst_data", 32'(bus.out_data), 32'h0);
        chk("t5_rst_stall", 32'(bus.stall_cnt), 32'h0);
        #10;
        ASYNCRESETN = 1'b1;
        tick();
        chk("t5_post_valid", 32'(bus.out_valid), 32'h0);
        chk("t5_post_data", 32'(bus.out_data), 32'h0);
        chk("t5_post_ready", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 3'b111;
        bus.in_valid  = 1'b1;
        bus.in_data   = 5'h15;
        tick();
        bus.in_valid = 1'b0;
        chk("t5_fresh_valid", 32'(bus.out_valid), 32'h7);
        chk("t5_fresh_data", 32'(bus.out_data), 32'h15);
        tick();
        chk("t5_fresh_empty", 32'(bus.out_valid), 32'h0);
        chk("t5_stall", 32'(bus.stall_cnt), 32'h0);

        // random traffic against a reference queue; last cycles drain
        for (int i = 0; i < N; i++) recv[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            minr = recv[0];
            for (int i = 1; i < N; i++) if (recv[i] < minr) minr = recv[i];
            occ = hist.size() - minr;
            for (int i = 0; i < N; i++) exp_v[i] = (occ > 0) && (recv[i] == minr);
            exp_rdy = (occ != HS_TX_DEPTH);
            chk("rnd_valid", 32'(bus.out_valid), 32'(exp_v));
            chk("rnd_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (cyc < 9980) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.in_data   = W'($urandom);
                bus.out_ready = N'($urandom);
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = '1;
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (exp_v[i] && bus.out_ready[i]) begin
                    chk("rnd_data", 32'(bus.out_data), 32'(hist[recv[i]]));
                    recv[i]++;
                end
            end
            if (bus.in_valid && exp_rdy) hist.push_back(bus.in_data);
            tick();
        end
        for (int i = 0; i < N; i++) begin
            chk("rnd_count", 32'(recv[i]), 32'(hist.size()));
        end
        chk("rnd_final_empty", 32'(bus.out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
